// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: accepts one 512-bit padded block and streams
// W_t together with K_t and the round index t, one round per handshake.
// A 16-word sliding window produces W_16..W_63 on the fly.
// Optional feature macro: MSG_SCHED_B2B_EN (accept the next block during the
// round-63 handshake so consecutive blocks stream without a bubble).
module sha256_msg_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         wt_valid,
  input  logic         wt_ready,
  output logic [31:0]  Wt_o,
  output logic [31:0]  Kt_o,
  output logic [5:0]   round_o,
  output logic         last_o,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state_q, state_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [5:0]  round_q, round_d;
  logic        load;
  logic        adv;
  logic        last_rnd;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Handshakes, window expansion and next-state selection
  always_comb begin
    last_rnd  = (round_q == 6'd63);
    adv       = (state_q == RUN) && wt_ready;
    blk_ready = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) begin
        blk_ready = 1'b1;
      end
`ifdef MSG_SCHED_B2B_EN
      else if (last_rnd && wt_ready) begin
        blk_ready = 1'b1;
      end
`endif
    end
    load  = blk_valid && blk_ready;
    w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    state_d = state_q;
    round_d = round_q;
    w_d     = w_q;
    // A load in RUN only happens alongside the round-63 handshake, so it
    // simply overrides the shift that would otherwise occur.
    if (load) begin
      for (int unsigned i = 0; i < 16; i++) begin
        w_d[i] = blk_data[32*(15-i) +: 32];
      end
      round_d = '0;
      state_d = RUN;
    end else if (adv) begin
      for (int unsigned i = 0; i < 15; i++) begin
        w_d[i] = w_q[i+1];
      end
      w_d[15] = w_new;
      round_d = round_q + 6'd1;
      if (last_rnd) begin
        state_d = IDLE;
      end
    end
  end

  // State, window and round registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      for (int unsigned i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  // Output mapping: W from the window head register, K from the round index
  always_comb begin
    wt_valid = (state_q == RUN);
    busy     = (state_q == RUN);
    Wt_o     = w_q[0];
    Kt_o     = K_ROM[round_q];
    round_o  = round_q;
    last_o   = (state_q == RUN) && last_rnd;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a full 64-word schedule model.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         wt_valid;
  logic         wt_ready;
  logic [31:0]  Wt_o;
  logic [31:0]  Kt_o;
  logic [5:0]   round_o;
  logic         last_o;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int acc_cyc;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [31:0] got_k [64];
  logic [5:0]  got_r [64];
  logic        got_l [64];
  logic        got_br[64];
  int          got_c [64];
  int          got_n;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ONES = '1;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .Wt_o      (Wt_o),
    .Kt_o      (Kt_o),
    .round_o   (round_o),
    .last_o    (last_o),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full schedule straight from the recurrence, stored as 64 words.
  task automatic build_model(input logic [511:0] b);
    logic [511:0] t;
    t = b;
    for (int i = 0; i < 16; i++) begin
      exp_w[i] = t[511:480];
      t = t << 32;
    end
    for (int i = 16; i < 64; i++) begin
      exp_w[i] = (rr(exp_w[i-2], 17) ^ rr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rr(exp_w[i-15], 7) ^ rr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
    return b;
  endfunction

  // Present a block and wait (bounded) until it is accepted; returns in the cycle after acceptance.
  task automatic load_block(input logic [511:0] d);
    bit ok;
    ok = 0;
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = d;
    wt_ready  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (blk_ready) begin
        acc_cyc = cyc_cnt;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL load_accept got=timeout exp=accepted");
      blk_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 blk_valid = 1'b0;
    end
  endtask

  // Consume rounds with wt_ready high, recording every transfer.
  task automatic collect_run();
    got_n = 0;
    for (int c = 0; c < 300 && got_n < 64; c++) begin
      @(negedge clk);
      wt_ready = 1'b1;
      #1;
      if (wt_valid && wt_ready) begin
        got_w[got_n]  = Wt_o;
        got_k[got_n]  = Kt_o;
        got_r[got_n]  = round_o;
        got_l[got_n]  = last_o;
        got_br[got_n] = blk_ready;
        got_c[got_n]  = cyc_cnt;
        got_n++;
      end
    end
    checks++;
    if (got_n != 64) begin
      failures++;
      $display("FAIL collect_count got=%0d exp=64", got_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b1; blk_data = rand_blk(); wt_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (blk_ready !== 1'b0) begin failures++; $display("FAIL rst_blk_ready got=%b exp=0", blk_ready); end
    checks++; if (wt_valid !== 1'b0) begin failures++; $display("FAIL rst_wt_valid got=%b exp=0", wt_valid); end
    checks++; if (round_o !== 6'd0) begin failures++; $display("FAIL rst_round got=%0d exp=0", round_o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (Wt_o !== 32'h0) begin failures++; $display("FAIL rst_wt got=%h exp=0", Wt_o); end
    checks++; if (Kt_o !== 32'h428a2f98) begin failures++; $display("FAIL rst_kt got=%h exp=428a2f98", Kt_o); end
    checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", last_o); end
    rst = 1'b0; blk_valid = 1'b0;
    #1;
    checks++; if (blk_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", blk_ready); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || wt_valid !== 1'b0) begin failures++; $display("FAIL rst_no_load busy=%b wt_valid=%b exp=0/0", busy, wt_valid); end
  endtask

  task automatic test_abc();
    build_model(ABC);
    load_block(ABC);
    collect_run();
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (got_w[t] !== exp_w[t] || got_k[t] !== KT[t] || got_r[t] !== 6'(t) || got_l[t] !== (t == 63) || got_c[t] != acc_cyc + 1 + t)
        begin failures++; $display("FAIL abc_round t=%0d got W=%h K=%h r=%0d l=%b cyc=%0d exp W=%h K=%h cyc=%0d",
          t, got_w[t], got_k[t], got_r[t], got_l[t], got_c[t], exp_w[t], KT[t], acc_cyc + 1 + t); end
    end
    checks++; if (got_w[0] !== 32'h61626380 || got_k[0] !== 32'h428a2f98) begin failures++; $display("FAIL abc_w0k0 got=%h/%h exp=61626380/428a2f98", got_w[0], got_k[0]); end
    checks++; if (got_w[15] !== 32'h00000018) begin failures++; $display("FAIL abc_w15 got=%h exp=00000018", got_w[15]); end
    checks++; if (got_w[16] !== 32'h61626380) begin failures++; $display("FAIL abc_w16 got=%h exp=61626380", got_w[16]); end
    checks++; if (got_w[17] !== 32'h000F0000) begin failures++; $display("FAIL abc_w17 got=%h exp=000F0000", got_w[17]); end
    checks++; if (got_k[63] !== 32'hc67178f2 || got_l[63] !== 1'b1) begin failures++; $display("FAIL abc_r63 got K=%h l=%b exp K=c67178f2 l=1", got_k[63], got_l[63]); end
`ifndef MSG_SCHED_B2B_EN
    checks++; if (got_br[63] !== 1'b0) begin failures++; $display("FAIL abc_ready_r63 got=%b exp=0", got_br[63]); end
`endif
    @(negedge clk); #1;
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b0 || cyc_cnt != acc_cyc + 65)
      begin failures++; $display("FAIL abc_idle got ready=%b busy=%b cyc=%0d exp 1/0/%0d", blk_ready, busy, cyc_cnt, acc_cyc + 65); end
  endtask

  task automatic test_wrap();
    build_model(ONES);
    load_block(ONES);
    collect_run();
    for (int t = 0; t < 16; t++) begin
      checks++; if (got_w[t] !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_w t=%0d got=%h exp=FFFFFFFF", t, got_w[t]); end
    end
    checks++; if (got_w[16] !== 32'h203FFFFC) begin failures++; $display("FAIL wrap_w16 got=%h exp=203FFFFC", got_w[16]); end
    for (int t = 16; t < 64; t++) begin
      checks++; if (got_w[t] !== exp_w[t]) begin failures++; $display("FAIL wrap_model t=%0d got=%h exp=%h", t, got_w[t], exp_w[t]); end
    end
  endtask

  task automatic test_random();
    logic [511:0] b;
    for (int k = 0; k < 3; k++) begin
      b = rand_blk();
      build_model(b);
      load_block(b);
      collect_run();
      for (int t = 0; t < 64; t++) begin
        checks++;
        if (got_w[t] !== exp_w[t] || got_k[t] !== KT[t] || got_r[t] !== 6'(t))
          begin failures++; $display("FAIL rand_round k=%0d t=%0d got W=%h K=%h r=%0d exp W=%h K=%h", k, t, got_w[t], got_k[t], got_r[t], exp_w[t], KT[t]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int phase, left, stall_checks;
    bit tog, held;
    logic [31:0] pw, pk;
    logic [5:0]  pr;
    build_model(ABC);
    load_block(ABC);
    phase = 0; left = 0; tog = 1'b1; held = 1'b0; stall_checks = 0; got_n = 0;
    pw = '0; pk = '0; pr = '0;
    for (int c = 0; c < 400 && got_n < 64; c++) begin
      @(negedge clk);
      if (phase == 0 && wt_valid && round_o == 6'd20) begin phase = 1; left = 5; end
      if (phase == 1) begin
        wt_ready = 1'b0;
        left--;
        if (left == 0) phase = 2;
      end else if (phase == 2) begin
        wt_ready = tog;
        tog = ~tog;
      end else begin
        wt_ready = 1'b1;
      end
      #1;
      if (held) begin
        checks++; stall_checks++;
        if (Wt_o !== pw || Kt_o !== pk || round_o !== pr)
          begin failures++; $display("FAIL stall_hold got W=%h K=%h r=%0d exp W=%h K=%h r=%0d", Wt_o, Kt_o, round_o, pw, pk, pr); end
      end
      held = wt_valid && !wt_ready;
      pw = Wt_o; pk = Kt_o; pr = round_o;
      if (wt_valid && wt_ready) begin
        got_w[got_n] = Wt_o; got_k[got_n] = Kt_o; got_r[got_n] = round_o; got_n++;
      end
    end
    wt_ready = 1'b1;
    checks++; if (got_n != 64 || stall_checks < 10) begin failures++; $display("FAIL bp_count got=%0d stalls=%0d exp=64 >=10", got_n, stall_checks); end
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (got_w[t] !== exp_w[t] || got_k[t] !== KT[t] || got_r[t] !== 6'(t))
        begin failures++; $display("FAIL bp_round t=%0d got W=%h K=%h r=%0d exp W=%h K=%h", t, got_w[t], got_k[t], got_r[t], exp_w[t], KT[t]); end
    end
    @(negedge clk);
  endtask

  task automatic test_block_during_run();
    logic [511:0] b;
    logic [31:0] all_w [128];
    logic [5:0]  all_r [128];
    int          all_c [128];
    int n, acc2, bubbles;
    bit armed;
    b = rand_blk();
    load_block(ABC);
    n = 0; acc2 = -1; bubbles = 0; armed = 0;
    for (int c = 0; c < 400 && n < 128; c++) begin
      @(negedge clk);
      wt_ready = 1'b1;
      if (acc2 >= 0) blk_valid = 1'b0;
      else if (!armed && wt_valid && round_o == 6'd10) begin armed = 1; blk_valid = 1'b1; blk_data = b; end
      #1;
      if (armed && acc2 < 0 && blk_valid && blk_ready) acc2 = cyc_cnt;
      if (n > 0 && !wt_valid) bubbles++;
      if (wt_valid && wt_ready) begin all_w[n] = Wt_o; all_r[n] = round_o; all_c[n] = cyc_cnt; n++; end
    end
    blk_valid = 1'b0;
    checks++; if (n != 128) begin failures++; $display("FAIL b2b_count got=%0d exp=128", n); end
`ifdef MSG_SCHED_B2B_EN
    checks++; if (acc2 != all_c[63]) begin failures++; $display("FAIL run_accept_cyc got=%0d exp=%0d", acc2, all_c[63]); end
    checks++; if (all_c[64] != all_c[63] + 1) begin failures++; $display("FAIL run_round0_cyc got=%0d exp=%0d", all_c[64], all_c[63] + 1); end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL run_bubbles got=%0d exp=0", bubbles); end
`else
    checks++; if (acc2 != all_c[63] + 1) begin failures++; $display("FAIL run_accept_cyc got=%0d exp=%0d", acc2, all_c[63] + 1); end
    checks++; if (all_c[64] != all_c[63] + 2) begin failures++; $display("FAIL run_round0_cyc got=%0d exp=%0d", all_c[64], all_c[63] + 2); end
    checks++; if (bubbles != 1) begin failures++; $display("FAIL run_bubbles got=%0d exp=1", bubbles); end
`endif
    build_model(ABC);
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (all_w[t] !== exp_w[t] || all_r[t] !== 6'(t)) begin failures++; $display("FAIL run_blkA t=%0d got W=%h r=%0d exp W=%h", t, all_w[t], all_r[t], exp_w[t]); end
    end
    build_model(b);
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (all_w[64+t] !== exp_w[t] || all_r[64+t] !== 6'(t)) begin failures++; $display("FAIL run_blkB t=%0d got W=%h r=%0d exp W=%h", t, all_w[64+t], all_r[64+t], exp_w[t]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit;
    load_block(ABC);
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      wt_ready = 1'b1;
      if (wt_valid && round_o == 6'd30) begin rst = 1'b1; hit = 1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rmid_reach got=timeout exp=round30"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (wt_valid !== 1'b0 || round_o !== 6'd0 || busy !== 1'b0 || Wt_o !== 32'h0)
      begin failures++; $display("FAIL rmid_state got v=%b r=%0d busy=%b W=%h exp 0/0/0/0", wt_valid, round_o, busy, Wt_o); end
    build_model(ABC);
    load_block(ABC);
    collect_run();
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (got_w[t] !== exp_w[t] || got_k[t] !== KT[t] || got_r[t] !== 6'(t))
        begin failures++; $display("FAIL rmid_round t=%0d got W=%h K=%h r=%0d exp W=%h K=%h", t, got_w[t], got_k[t], got_r[t], exp_w[t], KT[t]); end
    end
  endtask

  initial begin
    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; wt_ready = 1'b0;
    test_reset();
    test_abc();
    test_wrap();
    test_random();
    test_backpressure();
    test_block_during_run();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
